// File: rtl/stm1_deframer.sv
// STM-1 receive deframer: finds A1/A2 alignment, tracks row/column, and emits the
// 260x9 C-4 payload of each locked frame with one cycle of latency.
module stm1_deframer #(
    parameter int          STM1_LENGTH = 270,
    parameter int          STM1_WIDTH  = 9,
    parameter int          SOH_COLS    = 9,
    parameter int          POH_COLS    = 1,
    parameter logic [7:0]  A1_BYTE     = 8'hF6,
    parameter logic [7:0]  A2_BYTE     = 8'h28,
    parameter int          MISS_LIMIT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] stm_data,
    input  logic       stm_valid,
    output logic [7:0] c4_data,
    output logic       c4_valid,
    output logic       c4_sof,
    output logic       c4_sor,
    output logic       in_frame,
    output logic [8:0] col_idx,
    output logic [3:0] row_idx,
    output logic       oof_pulse
);

    localparam int PAYLOAD_COL = SOH_COLS + POH_COLS;
    localparam int CHECK_COL   = 5;
    localparam int MISS_W      = $clog2(MISS_LIMIT + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } state_t;

    state_t            state;
    logic [39:0]       sr;
    logic [MISS_W-1:0] miss;
    logic              armed;

    logic [8:0] nxt_col;
    logic [3:0] nxt_row;
    logic       match;
    logic       check_pt;

    // Position of the byte being accepted now, predicted from the last one.
    always_comb begin
        nxt_col = col_idx + 9'd1;
        nxt_row = row_idx;
        if (col_idx == 9'(STM1_LENGTH - 1)) begin
            nxt_col = '0;
            nxt_row = (row_idx == 4'(STM1_WIDTH - 1)) ? 4'd0 : row_idx + 4'd1;
        end
    end

    // sr keeps the five previous bytes; with the current byte that forms the six-byte window.
    assign match    = ({sr, stm_data} == {A1_BYTE, A1_BYTE, A1_BYTE, A2_BYTE, A2_BYTE, A2_BYTE});
    assign check_pt = (nxt_row == 4'd0) && (nxt_col == 9'(CHECK_COL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            sr        <= '0;
            miss      <= '0;
            armed     <= 1'b0;
            col_idx   <= '0;
            row_idx   <= '0;
            c4_data   <= '0;
            c4_valid  <= 1'b0;
            c4_sof    <= 1'b0;
            c4_sor    <= 1'b0;
            in_frame  <= 1'b0;
            oof_pulse <= 1'b0;
        end else begin
            c4_valid  <= 1'b0;
            c4_sof    <= 1'b0;
            c4_sor    <= 1'b0;
            oof_pulse <= 1'b0;
            if (stm_valid) begin
                sr      <= {sr[31:0], stm_data};
                col_idx <= nxt_col;
                row_idx <= nxt_row;

                // armed stays low for the frame in which SYNC was entered.
                if (state == SYNC && armed && nxt_col >= 9'(PAYLOAD_COL)) begin
                    c4_data  <= stm_data;
                    c4_valid <= 1'b1;
                    c4_sor   <= (nxt_col == 9'(PAYLOAD_COL));
                    c4_sof   <= (nxt_col == 9'(PAYLOAD_COL)) && (nxt_row == 4'd0);
                end

                case (state)
                    HUNT: begin
                        if (match) begin
                            col_idx <= 9'(CHECK_COL);
                            row_idx <= 4'd0;
                            state   <= PRESYNC;
                        end
                    end
                    PRESYNC: begin
                        if (check_pt) begin
                            if (match) begin
                                state    <= SYNC;
                                in_frame <= 1'b1;
                                miss     <= '0;
                                armed    <= 1'b0;
                            end else begin
                                state <= HUNT;
                            end
                        end
                    end
                    SYNC: begin
                        if (nxt_row == 4'd0 && nxt_col == 9'd0) begin
                            armed <= 1'b1;
                        end
                        if (check_pt) begin
                            if (match) begin
                                miss <= '0;
                            end else if (miss == MISS_W'(MISS_LIMIT - 1)) begin
                                state     <= HUNT;
                                in_frame  <= 1'b0;
                                oof_pulse <= 1'b1;
                                armed     <= 1'b0;
                                miss      <= '0;
                            end else begin
                                miss <= miss + MISS_W'(1);
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stm1_deframer.sv
// Bench for stm1_deframer: random STM-1 streams scored against a frame-level
// alignment model that walks the byte array from check point to check point.
module tb_stm1_deframer;

    localparam int FRAME_BYTES = 2430;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] stm_data = '0;
    logic       stm_valid = 1'b0;
    logic [7:0] c4_data;
    logic       c4_valid;
    logic       c4_sof;
    logic       c4_sor;
    logic       in_frame;
    logic [8:0] col_idx;
    logic [3:0] row_idx;
    logic       oof_pulse;

    always #5 clk = ~clk;

    stm1_deframer dut (
        .clk       (clk),
        .rst       (rst),
        .stm_data  (stm_data),
        .stm_valid (stm_valid),
        .c4_data   (c4_data),
        .c4_valid  (c4_valid),
        .c4_sof    (c4_sof),
        .c4_sor    (c4_sor),
        .in_frame  (in_frame),
        .col_idx   (col_idx),
        .row_idx   (row_idx),
        .oof_pulse (oof_pulse)
    );

    logic [7:0] stim_q[$];
    logic [9:0] exp_q[$];
    int         exp_sync_q[$];
    int         exp_oof_q[$];
    bit         model_in_frame;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int out_cnt  = 0;
    int oof_cnt  = 0;
    bit last_acc = 1'b0;
    bit prev_in_frame = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic build_frame(input bit ramp, input bit bad_fa, input bit false_fa);
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 270; c++) begin
                logic [7:0] b;
                if (r == 0 && c < 3)       b = 8'hF6;
                else if (r == 0 && c < 6)  b = (bad_fa && c == 5) ? 8'h00 : 8'h28;
                else if (c >= 10 && ramp)  b = 8'((r * 260 + c - 10) % 256);
                else                       b = 8'($urandom_range(0, 255));
                if (false_fa && r == 3 && c >= 100 && c < 106) b = (c < 103) ? 8'hF6 : 8'h28;
                stim_q.push_back(b);
            end
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit win_match(input int i);
        if (i < 5) return 1'b0;
        return stim_q[i-5] == 8'hF6 && stim_q[i-4] == 8'hF6 && stim_q[i-3] == 8'hF6 &&
               stim_q[i-2] == 8'h28 && stim_q[i-1] == 8'h28 && stim_q[i]   == 8'h28;
    endfunction

    task automatic emit_frame(input int base, input int n);
        for (int r = 0; r < 9; r++) begin
            for (int c = 10; c < 270; c++) begin
                int idx = base + r * 270 + c;
                if (idx < n) exp_q.push_back({(r == 0 && c == 10), (c == 10), stim_q[idx]});
            end
        end
    endtask

    // Positions are recorded as "bytes accepted so far" right after the deciding byte.
    task automatic run_model();
        int n    = stim_q.size();
        int i    = 5;
        int st   = 0;
        int chk  = 0;
        int miss = 0;
        while (1) begin
            if (st == 0) begin
                while (i < n && !win_match(i)) i++;
                if (i >= n) break;
                st  = 1;
                chk = i + FRAME_BYTES;
            end else begin
                if (chk >= n) break;
                if (st == 1) begin
                    if (win_match(chk)) begin
                        st   = 2;
                        miss = 0;
                        exp_sync_q.push_back(chk + 1);
                    end else begin
                        st = 0;
                        i  = chk + 1;
                    end
                end else begin
                    miss = win_match(chk) ? 0 : miss + 1;
                    if (miss == 4) begin
                        st = 0;
                        i  = chk + 1;
                        exp_oof_q.push_back(chk + 1);
                    end else begin
                        emit_frame(chk - 5, n);
                    end
                end
                chk += FRAME_BYTES;
            end
        end
        model_in_frame = (st == 2);
    endtask

    // ---------------- driver ----------------
    task automatic do_reset();
        rst       = 1'b1;
        stm_valid = 1'b0;
        stm_data  = '0;
        #1;
        check("rst_outputs", 32'({c4_data, c4_valid, c4_sof, c4_sor, in_frame,
                                  col_idx, row_idx, oof_pulse}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        last_acc = 1'b0;
        acc_cnt  = 0;
        out_cnt  = 0;
        oof_cnt  = 0;
        stim_q.delete();
        exp_q.delete();
        exp_sync_q.delete();
        exp_oof_q.delete();
    endtask

    task automatic drive_stream(input int gap_pct, input int idle);
        foreach (stim_q[k]) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                stm_valid = 1'b0;
                stm_data  = 8'($urandom_range(0, 255));
                @(posedge clk);
                #1;
                last_acc = 1'b0;
            end
            stm_valid = 1'b1;
            stm_data  = stim_q[k];
            @(posedge clk);
            #1;
            last_acc = 1'b1;
            acc_cnt++;
        end
        stm_valid = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
            last_acc = 1'b0;
        end
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_exp_left"}, 32'(exp_q.size()), 0);
        check({tag, "_sync_left"}, 32'(exp_sync_q.size()), 0);
        check({tag, "_oof_left"}, 32'(exp_oof_q.size()), 0);
        check({tag, "_in_frame"}, 32'(in_frame), 32'(model_in_frame));
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (!last_acc) check("gap_valid", 32'(c4_valid), 0);
            if (c4_valid) begin
                out_cnt++;
                if (exp_q.size() == 0) check("c4_extra", 32'(c4_valid), 0);
                else check("c4_word", 32'({c4_sof, c4_sor, c4_data}), 32'(exp_q.pop_front()));
            end
            if (in_frame && !prev_in_frame) begin
                if (exp_sync_q.size() == 0) check("sync_unexpected", 32'(in_frame), 0);
                else check("sync_pos", acc_cnt, exp_sync_q.pop_front());
            end
            if (oof_pulse) begin
                oof_cnt++;
                check("oof_in_frame", 32'(in_frame), 0);
                if (exp_oof_q.size() == 0) check("oof_unexpected", 32'(oof_pulse), 0);
                else check("oof_pos", acc_cnt, exp_oof_q.pop_front());
            end
        end
        prev_in_frame = in_frame;
    end

    // ---------------- scenarios ----------------
    initial begin
        #2;

        // Clean ramp-payload stream with heavy random gaps.
        do_reset();
        for (int f = 0; f < 3; f++) build_frame(1'b1, 1'b0, 1'b0);
        run_model();
        drive_stream(50, 3);
        end_checks("clean");
        check("clean_bytes", out_cnt, 2340);

        // False framing word inside the PRESYNC window.
        do_reset();
        build_frame(1'b0, 1'b0, 1'b1);
        build_frame(1'b0, 1'b0, 1'b0);
        build_frame(1'b0, 1'b0, 1'b0);
        run_model();
        drive_stream(0, 3);
        end_checks("false_fa");
        check("false_fa_bytes", out_cnt, 2340);

        // Three misses then recovery, later four misses and reacquisition.
        do_reset();
        for (int f = 0; f < 14; f++)
            build_frame(1'b0, (f >= 3 && f <= 5) || (f >= 7 && f <= 10), 1'b0);
        run_model();
        drive_stream(10, 3);
        end_checks("miss");
        check("miss_oof_count", oof_cnt, 1);
        check("miss_bytes", out_cnt, 9 * 2340);

        // Reset in the middle of a locked frame, then a fresh acquisition.
        do_reset();
        for (int f = 0; f < 3; f++) build_frame(1'b0, 1'b0, 1'b0);
        while (stim_q.size() > 2 * FRAME_BYTES + 4 * 270 + 150) void'(stim_q.pop_back());
        run_model();
        drive_stream(0, 1);
        end_checks("pre_rst");
        check("pre_rst_col", 32'(col_idx), 149);
        check("pre_rst_row", 32'(row_idx), 4);
        do_reset();
        for (int f = 0; f < 3; f++) build_frame(1'b0, 1'b0, 1'b0);
        run_model();
        drive_stream(20, 3);
        end_checks("post_rst");
        check("post_rst_bytes", out_cnt, 2340);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stm1_deframer.md
Name: stm1_deframer

Overview:
- Receive-side counterpart of the STM-1 frame builder.
- Accepts a serialized STM-1 byte stream (row-major, 270 columns x 9 rows), acquires frame alignment on the A1/A2 framing bytes, and tracks columns and rows.
- Strips section overhead (columns 0..8) and VC-4 POH (column 9), and emits the 260x9 C-4 payload bytes in row-major order.
- AU-4 pointer is treated as fixed: the VC-4 occupies columns 9..269 of every row. No pointer interpretation.

Parameters:
- STM1_LENGTH, 270, columns per STM-1 row
- STM1_WIDTH, 9, rows per frame
- SOH_COLS, 9, section overhead columns per row
- POH_COLS, 1, VC-4 path overhead columns per row (C-4 width = 270-9-1 = 260)
- A1_BYTE, 8'hF6, framing byte A1
- A2_BYTE, 8'h28, framing byte A2
- MISS_LIMIT, 4, consecutive bad framing words that declare loss of frame

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- stm_data  in  8  STM-1 stream byte
- stm_valid  in  1  stm_data valid this cycle; gaps allowed, no backpressure
- c4_data  out  8  C-4 payload byte
- c4_valid  out  1  c4_data valid
- c4_sof  out  1  with c4_valid: first C-4 byte of frame (row 0, C-4 col 0)
- c4_sor  out  1  with c4_valid: first C-4 byte of any row
- in_frame  out  1  1 while in state SYNC
- col_idx  out  9  current STM-1 column of last accepted byte (0..269)
- row_idx  out  4  current STM-1 row of last accepted byte (0..8)
- oof_pulse  out  1  one-cycle pulse on SYNC->HUNT transition

Behaviour:
- Reset (async, immediate): state=HUNT; all outputs 0; 6-byte shift register cleared; miss counter 0.
- All state advances only on cycles with stm_valid=1. Cycles with stm_valid=0 hold every register, and c4_valid=0 on the next cycle.
- 6-byte shift register holds the last 6 accepted bytes. Framing word match = F6 F6 F6 28 28 28, oldest first.
- Col/row counters:
  - On match in HUNT, the current byte is defined as row 0, col 5.
  - Each subsequent accepted byte increments col. Col 269 wraps to 0 and row increments. Row 8 col 269 wraps to row 0 col 0.
- "Check point" = an accepted byte at row 0 col 5 (counter-predicted).
- HUNT:
  - Counters free-run but are ignored; no payload output.
  - On match: load counters (row 0, col 5), go PRESYNC.
- PRESYNC:
  - At check point, match -> SYNC with miss counter 0; mismatch -> HUNT.
  - Matches elsewhere are ignored.
- SYNC:
  - At check point, match -> miss counter 0.
  - Mismatch -> miss counter +1. Reaching MISS_LIMIT -> HUNT and pulse oof_pulse.
- Payload output, SYNC only:
  - An accepted byte with col in 10..269 (any row) is registered to c4_data with c4_valid=1 on the next cycle.
  - c4_sor=1 when col=10. c4_sof=1 when col=10 and row=0.
  - Latency: exactly 1 clk from accepting the byte.
  - 2340 bytes per frame.
- State transitions take effect for the byte after the check point. The PRESYNC->SYNC frame itself is not output; output starts at row 0 col 10 of the next frame.
- A mid-frame drop to HUNT stops output immediately; a partial frame is not padded.
- Reset asserted mid-frame discards all state.
- in_frame changes are registered, aligned with the state register.

Test Plan:
- Clean stream: 3 consecutive valid frames, payload = (row*260+c4col) mod 256.
  - -> in_frame rises after 2nd frame check point.
  - 3rd frame yields 2340 c4_valid bytes, first byte 8'h00 with c4_sof=1, row 1 first byte 8'h04 with c4_sor=1.
- False A1A2 in payload during PRESYNC (pattern at row 3 col 100), true framing at next check point.
  - -> ignored; SYNC reached; no output before next frame.
- In SYNC, corrupt A2 in 3 consecutive frames, then a good frame.
  - -> no oof_pulse, miss counter resets, output continuous.
- Corrupt 4 consecutive framing words.
  - -> oof_pulse once at 4th check point, in_frame=0, c4_valid stays 0 until reacquired (2 good frames).
- Random stm_valid gaps (50% duty) on a synced stream.
  - -> identical c4_data sequence to gapless case, each byte 1 valid-clk after acceptance, no valid during gaps.
- Assert rst at row 4 col 150 in SYNC.
  - -> all outputs 0 immediately; reacquisition needs full HUNT/PRESYNC.
